// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle main control FSM for the MIPS-subset datapath
// (add, sub, and, addi, lw, sw, beq, j). Outputs decode from the state
// register, except PCWrite in BRANCH, which follows the ALU zero flag.
module mc_control_unit #(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemWR,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUOutWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       ovf_exc,
  output logic       ill_exc,
  output logic [3:0] state
);

  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_WAIT - 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,  S_ADDR   = 4'd5,  S_MEM_RD = 4'd6,  S_WB_MEM = 4'd7,
    S_MEM_WR = 4'd8,  S_WB_R   = 4'd9,  S_WB_I   = 4'd10, S_BRANCH = 4'd11,
    S_JUMP   = 4'd12, S_OVFL   = 4'd13, S_ILL    = 4'd14
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cnt_last_s;

  assign cnt_last_s = (cnt_q == CNT_LAST);
  assign state      = state_q;

  // State register and memory wait counter; reset aborts any access at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state selection and per-state output decode (counter idles at 0).
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemWR       = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUOutWrite = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 3'b000;
    PCSource    = 2'b00;
    ovf_exc     = 1'b0;
    ill_exc     = 1'b0;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        ALUSrcB = 2'b01;
        ALUOp   = 3'b001;
        if (cnt_last_s) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcB     = 2'b11;
        ALUOp       = 3'b001;
        ALUOutWrite = 1'b1;
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND) begin
              state_d = S_EXEC_R;
            end else begin
              state_d = S_ILL;
            end
          end
          OP_ADDI:      state_d = S_EXEC_I;
          OP_LW, OP_SW: state_d = S_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILL;
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ALUOutWrite = 1'b1;
        case (funct)
          FN_SUB:  ALUOp = 3'b010;
          FN_AND:  ALUOp = 3'b011;
          default: ALUOp = 3'b001;
        endcase
        // A logical AND cannot overflow, so its flag is disregarded.
        if (overflow && funct != FN_AND) begin
          state_d = S_OVFL;
        end else begin
          state_d = S_WB_R;
        end
      end
      S_EXEC_I: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 3'b001;
        ALUOutWrite = 1'b1;
        if (overflow) begin
          state_d = S_OVFL;
        end else begin
          state_d = S_WB_I;
        end
      end
      S_ADDR: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 3'b001;
        ALUOutWrite = 1'b1;
        if (opcode == OP_LW) begin
          state_d = S_MEM_RD;
        end else if (opcode == OP_SW) begin
          state_d = S_MEM_WR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM_RD: begin
        IorD = 1'b1;
        if (cnt_last_s) begin
          state_d = S_WB_MEM;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_MEM_RD;
        end
      end
      S_WB_MEM: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        IorD    = 1'b1;
        MemWR   = 1'b1;
        state_d = S_FETCH;
      end
      S_WB_R: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_WB_I: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        ALUOp    = 3'b010;
        PCSource = 2'b01;
        PCWrite  = zero;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
        state_d  = S_FETCH;
      end
      S_OVFL: begin
        ovf_exc = 1'b1;
        state_d = S_FETCH;
      end
      S_ILL: begin
        ill_exc = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_RST;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit (MEM_WAIT=2): table of instruction
// vectors, each expanding into per-cycle expected records in a scoreboard.
module tb_mc_control_unit;

  typedef struct packed {
    logic       pcw, iord, memwr, irw, regdst, m2r, regw, aluow, srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       ovf, ill;
  } outs_t;

  typedef struct packed {
    logic [3:0] st;
    outs_t      o;
  } exp_t;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        ov;
    int          len;
    logic [31:0] path;   // one state code per nibble, first state in the top nibble
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, overflow;
  logic       PCWrite, IorD, MemWR, IRWrite, RegDst, MemtoReg, RegWrite, ALUOutWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic       ovf_exc, ill_exc;
  logic [3:0] state;

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb_q[$];
  vec_t vec[14];

  mc_control_unit #(.MEM_WAIT(2)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .PCWrite(PCWrite), .IorD(IorD), .MemWR(MemWR),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUOutWrite(ALUOutWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .ovf_exc(ovf_exc), .ill_exc(ill_exc), .state(state)
  );

  always #5 clk = ~clk;

  function automatic outs_t actual_outs();
    outs_t a;
    a = '{PCWrite, IorD, MemWR, IRWrite, RegDst, MemtoReg, RegWrite, ALUOutWrite,
          ALUSrcA, ALUSrcB, ALUOp, PCSource, ovf_exc, ill_exc};
    return a;
  endfunction

  // Expected outputs for one state, straight from the per-state output list.
  function automatic outs_t exp_outs(input logic [3:0] st, input logic last,
                                     input logic [5:0] fn, input logic z);
    outs_t o;
    o = '0;
    case (st)
      4'd1:  begin o.srcb = 2'b01; o.aluop = 3'b001; o.irw = last; o.pcw = last; end
      4'd2:  begin o.srcb = 2'b11; o.aluop = 3'b001; o.aluow = 1'b1; end
      4'd3:  begin
        o.srca = 1'b1; o.srcb = 2'b10; o.aluow = 1'b1;
        o.aluop = (fn == 6'h22) ? 3'b010 : (fn == 6'h24) ? 3'b011 : 3'b001;
      end
      4'd4, 4'd5: begin o.srca = 1'b1; o.srcb = 2'b00; o.aluop = 3'b001; o.aluow = 1'b1; end
      4'd6:  o.iord = 1'b1;
      4'd7:  begin o.m2r = 1'b1; o.regw = 1'b1; end
      4'd8:  begin o.iord = 1'b1; o.memwr = 1'b1; end
      4'd9:  begin o.regdst = 1'b1; o.regw = 1'b1; end
      4'd10: o.regw = 1'b1;
      4'd11: begin o.srca = 1'b1; o.srcb = 2'b10; o.aluop = 3'b010; o.pcsrc = 2'b01; o.pcw = z; end
      4'd12: begin o.pcsrc = 2'b10; o.pcw = 1'b1; end
      4'd13: o.ovf = 1'b1;
      4'd14: o.ill = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic check(input string name, input exp_t e);
    outs_t a;
    a = actual_outs();
    tests_run++;
    if (state !== e.st || a !== e.o) begin
      tests_failed++;
      $display("FAIL %s: state=%0d outs=%h, expected state=%0d outs=%h",
               name, state, a, e.st, e.o);
    end
  endtask

  // Expand a vector's state path into per-cycle expected records, drive it, and drain.
  task automatic run_vec(input vec_t v);
    logic [31:0] p;
    logic [3:0]  st, nx;
    exp_t        e;
    opcode = v.op; funct = v.fn; zero = v.z; overflow = v.ov;
    for (int i = 0; i < v.len; i++) begin
      p  = v.path >> (4 * (v.len - 1 - i));
      st = p[3:0];
      if (i + 1 < v.len) begin
        p  = v.path >> (4 * (v.len - 2 - i));
        nx = p[3:0];
      end else begin
        nx = 4'd1;
      end
      e.st = st;
      e.o  = exp_outs(st, (st == 4'd1) && (nx != 4'd1), v.fn, v.z);
      sb_q.push_back(e);
    end
    while (sb_q.size() > 0) begin
      @(posedge clk);
      #1;
      check(v.name, sb_q.pop_front());
    end
  endtask

  initial begin
    vec[0]  = '{"add",      6'h00, 6'h20, 1'b0, 1'b0, 5, 32'h11239};
    vec[1]  = '{"sub",      6'h00, 6'h22, 1'b1, 1'b0, 5, 32'h11239};
    vec[2]  = '{"and_ovf",  6'h00, 6'h24, 1'b0, 1'b1, 5, 32'h11239};
    vec[3]  = '{"sub_ovf",  6'h00, 6'h22, 1'b0, 1'b1, 5, 32'h1123D};
    vec[4]  = '{"add_ovf",  6'h00, 6'h20, 1'b0, 1'b1, 5, 32'h1123D};
    vec[5]  = '{"addi",     6'h08, 6'h11, 1'b0, 1'b0, 5, 32'h1124A};
    vec[6]  = '{"addi_ovf", 6'h08, 6'h00, 1'b1, 1'b1, 5, 32'h1124D};
    vec[7]  = '{"lw",       6'h23, 6'h22, 1'b0, 1'b1, 7, 32'h1125667};
    vec[8]  = '{"sw",       6'h2B, 6'h20, 1'b1, 1'b0, 5, 32'h11258};
    vec[9]  = '{"beq_t",    6'h04, 6'h00, 1'b1, 1'b1, 4, 32'h112B};
    vec[10] = '{"beq_nt",   6'h04, 6'h20, 1'b0, 1'b0, 4, 32'h112B};
    vec[11] = '{"j",        6'h02, 6'h24, 1'b0, 1'b1, 4, 32'h112C};
    vec[12] = '{"ill_op",   6'h3F, 6'h20, 1'b0, 1'b0, 4, 32'h112E};
    vec[13] = '{"ill_fn",   6'h00, 6'h25, 1'b0, 1'b1, 4, 32'h112E};

    // Reset held low with random inputs: everything stays at zero.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      opcode = 6'($urandom); funct = 6'($urandom);
      zero = 1'($urandom); overflow = 1'($urandom);
      @(posedge clk);
      #1;
      check("reset_hold", '0);
    end
    reset = 1'b1;
    #1;
    check("reset_release", '0);

    foreach (vec[i]) run_vec(vec[i]);

    // Load aborted by reset on its second memory-read cycle.
    run_vec('{"lw_abort", 6'h23, 6'h00, 1'b0, 1'b0, 6, 32'h112566});
    reset = 1'b0;
    #1;
    check("abort_async", '0);
    @(posedge clk);
    #1;
    check("abort_hold", '0);
    reset = 1'b1;
    #1;
    check("abort_release", '0);
    run_vec('{"add_after_abort", 6'h00, 6'h20, 1'b0, 1'b0, 5, 32'h11239});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multicycle main control FSM for the MIPS-subset datapath. It sequences PC, instruction register, memory, register file and the ALU operand muxes: ALUSrcA picks PC or A, and the 2-bit ALUSrcB picks sign-extended immediate, constant 4, B or immediate shifted left by 2. It sits beside the datapath and drives every mux select and write enable from a Moore state register, with one Mealy exception (branch PC write). Supported instructions: add, sub, and, addi, lw, sw, beq, j.

## Interface
- MEM_WAIT, 2, memory access latency in cycles (>=1); used for fetch and load.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- overflow  in  1  ALU signed-overflow flag
- PCWrite  out  1  PC load enable
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- MemWR  out  1  memory write enable
- IRWrite  out  1  instruction register load
- RegDst  out  1  write register: 0=rt, 1=rd
- MemtoReg  out  1  write data: 0=ALUOut, 1=MDR
- RegWrite  out  1  register file write enable
- ALUOutWrite  out  1  ALUOut register load
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  00=SE imm, 01=const 4, 10=B, 11=SE imm<<2
- ALUOp  out  3  000=pass A, 001=add, 010=sub, 011=and
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- ovf_exc  out  1  one-cycle overflow exception pulse
- ill_exc  out  1  one-cycle illegal-instruction pulse
- state  out  4  current state code (debug)

## Operation
- States and codes: RST=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, ADDR=5, MEM_RD=6, WB_MEM=7, MEM_WR=8, WB_R=9, WB_I=10, BRANCH=11, JUMP=12, OVFL=13, ILL=14.
- Any output not listed for a state is 0.
- RST: all outputs 0. Goes to FETCH.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=001, PCSource=00. A wait counter runs 0..MEM_WAIT-1. IRWrite=1 and PCWrite=1 only when the counter equals MEM_WAIT-1, after which the FSM goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=001, ALUOutWrite=1 (precomputes the branch target). Next state by opcode:
  - 0x00: funct 0x20, 0x22 or 0x24 → EXEC_R; any other funct → ILL.
  - 0x08 → EXEC_I.
  - 0x23 or 0x2B → ADDR.
  - 0x04 → BRANCH.
  - 0x02 → JUMP.
  - anything else → ILL.
- EXEC_R: ALUSrcA=1, ALUSrcB=10, ALUOutWrite=1. ALUOp is 001, 010 or 011 for funct 0x20, 0x22, 0x24. If overflow=1 and funct≠0x24 → OVFL, else → WB_R.
- EXEC_I: ALUSrcA=1, ALUSrcB=00, ALUOp=001, ALUOutWrite=1. If overflow=1 → OVFL, else → WB_I.
- ADDR: ALUSrcA=1, ALUSrcB=00, ALUOp=001, ALUOutWrite=1. Opcode 0x23 → MEM_RD; 0x2B → MEM_WR.
- MEM_RD: IorD=1. Waits MEM_WAIT cycles on the wait counter, then → WB_MEM.
- WB_MEM: RegDst=0, MemtoReg=1, RegWrite=1 → FETCH.
- MEM_WR: IorD=1, MemWR=1 for exactly one cycle → FETCH.
- WB_R: RegDst=1, MemtoReg=0, RegWrite=1 → FETCH.
- WB_I: RegDst=0, MemtoReg=0, RegWrite=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=10, ALUOp=010, PCSource=01. PCWrite=zero (combinational; the only Mealy output). → FETCH.
- JUMP: PCSource=10, PCWrite=1 → FETCH.
- OVFL: ovf_exc=1. RegWrite stays 0 (the destination register is never written). → FETCH.
- ILL: ill_exc=1 → FETCH.
- Opcode and funct are sampled in DECODE and EXEC/ADDR. The IR is stable there because IRWrite is 0 outside FETCH.

## Timing
- reset=0 at any time, including mid-fetch or mid-memory access: state forced to RST and the wait counter cleared to 0 immediately. All outputs are 0 while reset is low.
- First FETCH cycle occurs one clock edge after reset deasserts, since RST lasts 1 cycle.
- Cycles per instruction, with W=MEM_WAIT:
  - R-type and addi: W+3.
  - lw: 2W+3.
  - sw: W+3.
  - beq and j: W+2.
  - overflow or illegal: W+3 for R-type/addi overflow, W+2 for illegal.
- The wait counter clears on every entry to FETCH or MEM_RD. With W=1 each of those states lasts a single cycle.
- overflow and zero are sampled only in EXEC_R/EXEC_I and BRANCH respectively, and ignored in all other states.

## Test plan
- Reset and first fetch, W=2: hold reset low 3 cycles with random inputs → all outputs 0 and state=0. After release: state=1 for 2 cycles, with IRWrite=PCWrite=1 only on the second, then state=2.
- add, opcode 0x00 funct 0x20, overflow=0 → states 1,1,2,3,9. ALUSrcB=10 and ALUOp=001 in EXEC_R; RegWrite=1 and RegDst=1 in WB_R; 5 cycles total.
- lw, opcode 0x23, W=2 → states 1,1,2,5,6,6,7. IorD=1 in MEM_RD; MemtoReg=RegWrite=1 in WB_MEM; 7 cycles. sw (0x2B) → MemWR=1 for exactly one cycle.
- beq, opcode 0x04: with zero=1 → PCWrite=1 and PCSource=01 in BRANCH; with zero=0 → PCWrite=0. ALUSrcB=11 in DECODE.
- addi with overflow=1 in EXEC_I → state 13, ovf_exc high 1 cycle, RegWrite never asserted. Repeat with opcode 0x3F → state 14 and ill_exc pulse; R-type funct 0x25 → ill_exc pulse.
- Assert reset mid-MEM_RD on a lw → immediate return to state 0. After release, fetch restarts with the counter at 0, and no RegWrite occurs for the aborted load.
